// File: rtl/grid_cell_tracker.sv
// grid_cell_tracker: pipelined pixel-to-grid-cell mapper with cursor and per-cell mark mask
module grid_cell_tracker #(
  parameter int W      = 10,
  parameter int COLS   = 3,
  parameter int ROWS   = 3,
  parameter int X0     = 96,
  parameter int Y0     = 2,
  parameter int CELL_W = 224,
  parameter int CELL_H = 170,
  parameter int LINE_W = 2,
  localparam int CW    = $clog2(COLS),
  localparam int RW    = $clog2(ROWS),
  localparam int N     = ROWS * COLS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  pixelx,
  input  logic [W-1:0]  pixely,
  input  logic          pix_valid,
  input  logic          mv_up,
  input  logic          mv_down,
  input  logic          mv_left,
  input  logic          mv_right,
  input  logic          sel,
  input  logic          clr,
  output logic          cell_valid,
  output logic [CW-1:0] cell_col,
  output logic [RW-1:0] cell_row,
  output logic [W-1:0]  posx,
  output logic [W-1:0]  posy,
  output logic          on_line,
  output logic          is_cursor,
  output logic          is_marked,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic          sel_accept,
  output logic          sel_reject,
  output logic [N-1:0]  mark_mask
);
  logic [31:0]   xe, ye, xb, yb;
  logic [CW-1:0] col_d, col1_q, col2_d, col2_q, ccol_d, ccol_q;
  logic [RW-1:0] row_d, row1_q, row2_d, row2_q, crow_d, crow_q;
  logic          inx_d, iny_d, lx_d, ly_d;
  logic          v1_q, inx1_q, iny1_q, lx1_q, ly1_q;
  logic          cv_d, cv_q, on_d, on_q, cur_d, cur_q, mk_d, mk_q;
  logic [W-1:0]  posx_d, posx_q, posy_d, posy_q;
  logic [N-1:0]  mask_d, mask_q, cur_bit, mk_sh;
  logic          hit, acc_d, acc_q, rej_d, rej_q;
  assign xe = 32'(pixelx);
  assign ye = 32'(pixely);
  // stage 1 decode: the last constant boundary not above the pixel selects the cell and its base
  always_comb begin
    col_d = '0;
    row_d = '0;
    xb    = 32'(X0);
    yb    = 32'(Y0);
    for (int k = 1; k < COLS; k++)
      if (xe >= 32'(X0 + k * CELL_W)) begin
        col_d = CW'(k);
        xb    = 32'(X0 + k * CELL_W);
      end
    for (int k = 1; k < ROWS; k++)
      if (ye >= 32'(Y0 + k * CELL_H)) begin
        row_d = RW'(k);
        yb    = 32'(Y0 + k * CELL_H);
      end
    inx_d = xe >= 32'(X0) && xe < 32'(X0 + COLS * CELL_W);
    iny_d = ye >= 32'(Y0) && ye < 32'(Y0 + ROWS * CELL_H);
    lx_d  = (xe - xb) < 32'(LINE_W);
    ly_d  = (ye - yb) < 32'(LINE_W);
  end
  // stage 2 outputs: everything is forced to zero outside the grid
  always_comb begin
    cv_d   = v1_q & inx1_q & iny1_q;
    col2_d = cv_d ? col1_q : '0;
    row2_d = cv_d ? row1_q : '0;
    posx_d = cv_d ? W'(32'(X0) + 32'(col1_q) * 32'(CELL_W) + 32'(CELL_W / 2)) : '0;
    posy_d = cv_d ? W'(32'(Y0) + 32'(row1_q) * 32'(CELL_H) + 32'(CELL_H / 2)) : '0;
    on_d   = cv_d & (lx1_q | ly1_q);
    cur_d  = cv_d & (col1_q == ccol_q) & (row1_q == crow_q);
    mk_sh  = mask_q >> (32'(row1_q) * 32'(COLS) + 32'(col1_q));
    mk_d   = cv_d & mk_sh[0];
  end
  // cursor moves (up > down > left > right, wrapping) and select/clear against the pre-move cell
  always_comb begin
    crow_d  = mv_up   ? (crow_q == '0 ? RW'(ROWS - 1) : crow_q - 1'b1) :
              mv_down ? (crow_q == RW'(ROWS - 1) ? '0 : crow_q + 1'b1) : crow_q;
    ccol_d  = (mv_up | mv_down) ? ccol_q :
              mv_left  ? (ccol_q == '0 ? CW'(COLS - 1) : ccol_q - 1'b1) :
              mv_right ? (ccol_q == CW'(COLS - 1) ? '0 : ccol_q + 1'b1) : ccol_q;
    cur_bit = N'(1) << (32'(crow_q) * 32'(COLS) + 32'(ccol_q));
    hit     = |(mask_q & cur_bit);
    acc_d   = ~clr & sel & ~hit;
    rej_d   = ~clr & sel & hit;
    mask_d  = clr ? '0 : acc_d ? (mask_q | cur_bit) : mask_q;
  end
  // all state: two pixel pipeline stages plus cursor/mask registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      col1_q <= '0;
      row1_q <= '0;
      inx1_q <= 1'b0;
      iny1_q <= 1'b0;
      lx1_q  <= 1'b0;
      ly1_q  <= 1'b0;
      cv_q   <= 1'b0;
      col2_q <= '0;
      row2_q <= '0;
      posx_q <= '0;
      posy_q <= '0;
      on_q   <= 1'b0;
      cur_q  <= 1'b0;
      mk_q   <= 1'b0;
      ccol_q <= '0;
      crow_q <= '0;
      mask_q <= '0;
      acc_q  <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      v1_q   <= pix_valid;
      col1_q <= col_d;
      row1_q <= row_d;
      inx1_q <= inx_d;
      iny1_q <= iny_d;
      lx1_q  <= lx_d;
      ly1_q  <= ly_d;
      cv_q   <= cv_d;
      col2_q <= col2_d;
      row2_q <= row2_d;
      posx_q <= posx_d;
      posy_q <= posy_d;
      on_q   <= on_d;
      cur_q  <= cur_d;
      mk_q   <= mk_d;
      ccol_q <= ccol_d;
      crow_q <= crow_d;
      mask_q <= mask_d;
      acc_q  <= acc_d;
      rej_q  <= rej_d;
    end
  end
  assign cell_valid = cv_q;
  assign cell_col   = col2_q;
  assign cell_row   = row2_q;
  assign posx       = posx_q;
  assign posy       = posy_q;
  assign on_line    = on_q;
  assign is_cursor  = cur_q;
  assign is_marked  = mk_q;
  assign cursor_col = ccol_q;
  assign cursor_row = crow_q;
  assign sel_accept = acc_q;
  assign sel_reject = rej_q;
  assign mark_mask  = mask_q;
endmodule

// File: tb/tb_grid_cell_tracker.sv
// tb_grid_cell_tracker: directed self-checking bench for grid_cell_tracker
module tb_grid_cell_tracker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pixelx = '0, pixely = '0;
  logic       pix_valid = 1'b0;
  logic       mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0, sel = 1'b0, clr = 1'b0;
  logic       cell_valid, on_line, is_cursor, is_marked, sel_accept, sel_reject;
  logic [1:0] cell_col, cell_row, cursor_col, cursor_row;
  logic [9:0] posx, posy;
  logic [8:0] mark_mask;
  logic [27:0] pix_out;
  int tests = 0, fails = 0;

  grid_cell_tracker dut (
    .clk(clk), .rst_n(rst_n), .pixelx(pixelx), .pixely(pixely), .pix_valid(pix_valid),
    .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
    .sel(sel), .clr(clr), .cell_valid(cell_valid), .cell_col(cell_col), .cell_row(cell_row),
    .posx(posx), .posy(posy), .on_line(on_line), .is_cursor(is_cursor), .is_marked(is_marked),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .sel_accept(sel_accept),
    .sel_reject(sel_reject), .mark_mask(mark_mask)
  );

  always #5 clk = ~clk;
  assign pix_out = {cell_valid, cell_col, cell_row, posx, posy, on_line, is_cursor, is_marked};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic v);
    pixelx = x;
    pixely = y;
    pix_valid = v;
    tick();
    tick();
  endtask

  task automatic pulse(input logic [5:0] p);
    {mv_up, mv_down, mv_left, mv_right, sel, clr} = p;
    tick();
    {mv_up, mv_down, mv_left, mv_right, sel, clr} = '0;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    tests++;
    if ({pix_out, cursor_col, cursor_row, sel_accept, sel_reject, mark_mask} !== '0) begin
      fails++;
      $display("FAIL reset_state got pix=%h cur=%0d/%0d mask=%h exp all 0", pix_out, cursor_col, cursor_row, mark_mask);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode;
    drive_pix(10'd96, 10'd2, 1'b1);
    tests++;
    if (pix_out !== {1'b1, 2'd0, 2'd0, 10'd208, 10'd87, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL decode_corner got %h exp %h", pix_out, {1'b1, 2'd0, 2'd0, 10'd208, 10'd87, 1'b1, 1'b1, 1'b0});
    end
    drive_pix(10'd432, 10'd257, 1'b1);
    tests++;
    if (pix_out !== {1'b1, 2'd1, 2'd1, 10'd432, 10'd257, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL decode_centre got %h exp %h", pix_out, {1'b1, 2'd1, 2'd1, 10'd432, 10'd257, 1'b0, 1'b0, 1'b0});
    end
    drive_pix(10'd767, 10'd511, 1'b1);
    tests++;
    if (pix_out !== {1'b1, 2'd2, 2'd2, 10'd656, 10'd427, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL decode_last got %h exp %h", pix_out, {1'b1, 2'd2, 2'd2, 10'd656, 10'd427, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_out_of_grid;
    logic [9:0] xs [4] = '{10'd768, 10'd95, 10'd300, 10'd300};
    logic [9:0] ys [4] = '{10'd300, 10'd300, 10'd512, 10'd100};
    logic       vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_pix(xs[i], ys[i], vs[i]);
      tests++;
      if (pix_out !== '0) begin
        fails++;
        $display("FAIL out_of_grid_%0d (%0d,%0d,v=%0d) got %h exp 0", i, xs[i], ys[i], vs[i], pix_out);
      end
    end
  endtask

  task automatic test_cursor;
    pulse(6'b001000);
    tests++;
    if ({cursor_col, cursor_row} !== {2'd2, 2'd0}) begin
      fails++;
      $display("FAIL cursor_left_wrap got col=%0d row=%0d exp col=2 row=0", cursor_col, cursor_row);
    end
    pulse(6'b100000);
    tests++;
    if ({cursor_col, cursor_row} !== {2'd2, 2'd2}) begin
      fails++;
      $display("FAIL cursor_up_wrap got col=%0d row=%0d exp col=2 row=2", cursor_col, cursor_row);
    end
    pulse(6'b100100);
    tests++;
    if ({cursor_col, cursor_row} !== {2'd2, 2'd1}) begin
      fails++;
      $display("FAIL cursor_priority got col=%0d row=%0d exp col=2 row=1", cursor_col, cursor_row);
    end
    pulse(6'b010000);
    pulse(6'b010000);
    tests++;
    if ({cursor_col, cursor_row} !== {2'd2, 2'd0}) begin
      fails++;
      $display("FAIL cursor_down_wrap got col=%0d row=%0d exp col=2 row=0", cursor_col, cursor_row);
    end
    pulse(6'b000100);
    tests++;
    if ({cursor_col, cursor_row} !== {2'd0, 2'd0}) begin
      fails++;
      $display("FAIL cursor_right_wrap got col=%0d row=%0d exp col=0 row=0", cursor_col, cursor_row);
    end
  endtask

  task automatic test_marks;
    pulse(6'b000010);
    tests++;
    if ({sel_accept, sel_reject, mark_mask} !== {1'b1, 1'b0, 9'h001}) begin
      fails++;
      $display("FAIL sel_accept got acc=%0d rej=%0d mask=%h exp acc=1 rej=0 mask=001", sel_accept, sel_reject, mark_mask);
    end
    tick();
    tests++;
    if ({sel_accept, sel_reject} !== 2'b00) begin
      fails++;
      $display("FAIL sel_pulse_width got acc=%0d rej=%0d exp 0 0", sel_accept, sel_reject);
    end
    pulse(6'b000010);
    tests++;
    if ({sel_accept, sel_reject, mark_mask} !== {1'b0, 1'b1, 9'h001}) begin
      fails++;
      $display("FAIL sel_reject got acc=%0d rej=%0d mask=%h exp acc=0 rej=1 mask=001", sel_accept, sel_reject, mark_mask);
    end
    pulse(6'b000011);
    tests++;
    if ({sel_accept, sel_reject, mark_mask} !== {1'b0, 1'b0, 9'h000}) begin
      fails++;
      $display("FAIL clr_wins got acc=%0d rej=%0d mask=%h exp acc=0 rej=0 mask=000", sel_accept, sel_reject, mark_mask);
    end
    pulse(6'b000110);
    tests++;
    if ({sel_accept, mark_mask, cursor_col, cursor_row} !== {1'b1, 9'h001, 2'd1, 2'd0}) begin
      fails++;
      $display("FAIL sel_premove got acc=%0d mask=%h col=%0d row=%0d exp acc=1 mask=001 col=1 row=0", sel_accept, mark_mask, cursor_col, cursor_row);
    end
  endtask

  task automatic test_highlight;
    pulse(6'b000001);
    pulse(6'b010000);
    pulse(6'b000010);
    tests++;
    if ({mark_mask, cursor_col, cursor_row} !== {9'h010, 2'd1, 2'd1}) begin
      fails++;
      $display("FAIL highlight_setup got mask=%h col=%0d row=%0d exp mask=010 col=1 row=1", mark_mask, cursor_col, cursor_row);
    end
    drive_pix(10'd432, 10'd257, 1'b1);
    tests++;
    if (pix_out !== {1'b1, 2'd1, 2'd1, 10'd432, 10'd257, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL highlight_hit got %h exp %h", pix_out, {1'b1, 2'd1, 2'd1, 10'd432, 10'd257, 1'b0, 1'b1, 1'b1});
    end
    drive_pix(10'd208, 10'd87, 1'b1);
    tests++;
    if (pix_out !== {1'b1, 2'd0, 2'd0, 10'd208, 10'd87, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL highlight_miss got %h exp %h", pix_out, {1'b1, 2'd0, 2'd0, 10'd208, 10'd87, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_async_reset;
    drive_pix(10'd432, 10'd257, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({pix_out, cursor_col, cursor_row, sel_accept, sel_reject, mark_mask} !== '0) begin
      fails++;
      $display("FAIL async_reset got pix=%h cur=%0d/%0d mask=%h exp all 0", pix_out, cursor_col, cursor_row, mark_mask);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if ({cell_valid, cursor_col, cursor_row, mark_mask} !== '0) begin
      fails++;
      $display("FAIL post_reset_stage1 got valid=%0d cur=%0d/%0d mask=%h exp all 0", cell_valid, cursor_col, cursor_row, mark_mask);
    end
    tick();
    tests++;
    if (pix_out !== {1'b1, 2'd1, 2'd1, 10'd432, 10'd257, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL post_reset_latency got %h exp %h", pix_out, {1'b1, 2'd1, 2'd1, 10'd432, 10'd257, 1'b0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_out_of_grid();
    test_cursor();
    test_marks();
    test_highlight();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grid_cell_tracker.md
Name: grid_cell_tracker

Overview:
- Parametrised, pipelined successor to the fixed 3x3 pixel-to-cell mapper in the VGA board-game datapath.
- Maps the scanning pixel coordinate to a cell of a ROWS x COLS grid, and reports that cell's index and centre position plus a grid-line flag.
- Also owns the player cursor (moved by button pulses, with wrap-around) and a per-cell mark mask updated by select/clear commands.
- Sits between the VGA sync counter and the sprite/colour mux.

Parameters:
- W, 10, pixel coordinate width
- COLS, 3, grid columns (>=2)
- ROWS, 3, grid rows (>=2)
- X0, 96, left edge of grid (pixels)
- Y0, 2, top edge of grid (pixels)
- CELL_W, 224, cell width
- CELL_H, 170, cell height
- LINE_W, 2, grid-line thickness at the left/top of each cell
- Derived: CW = $clog2(COLS), RW = $clog2(ROWS)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pixelx  in  W  current pixel x
- pixely  in  W  current pixel y
- pix_valid  in  1  pixel is in the active video region
- mv_up, mv_down, mv_left, mv_right  in  1 each  one-cycle cursor move pulses
- sel  in  1  one-cycle select pulse
- clr  in  1  one-cycle clear-all-marks pulse
- cell_valid  out  1  pixel lies inside the grid
- cell_col  out  CW  column of the pixel
- cell_row  out  RW  row of the pixel
- posx  out  W  centre x of that cell
- posy  out  W  centre y of that cell
- on_line  out  1  pixel is on a grid line
- is_cursor  out  1  pixel's cell equals the cursor cell
- is_marked  out  1  pixel's cell is marked
- cursor_col  out  CW  cursor column
- cursor_row  out  RW  cursor row
- sel_accept  out  1  select succeeded (pulse)
- sel_reject  out  1  select hit a marked cell (pulse)
- mark_mask  out  ROWS*COLS  mark bits; bit index = row*COLS+col

Behaviour:
- Reset (async, rst_n=0): every output and internal register goes to 0, including cursor (0,0), mark_mask, and both pipeline stages. Registers are released on the first clk edge after rst_n rises.
- Column k spans [X0+k*CELL_W, X0+(k+1)*CELL_W); the left bound is inclusive, the right bound exclusive. Rows are defined the same way with Y0 and CELL_H.
- Pixels below X0/Y0, or at or beyond X0+COLS*CELL_W or Y0+ROWS*CELL_H, are out of grid.
- Cell decode uses a constant-boundary comparator chain only; no divider.
- Pipeline latency is exactly 2 cycles from (pixelx, pixely, pix_valid) to all pixel-related outputs.
  - Stage 1 registers the column/row indices, the in-range flags and the line flags.
  - Stage 2 registers cell_valid, cell_col, cell_row, posx, posy, on_line, is_cursor and is_marked.
- cell_valid = pix_valid AND in-x-range AND in-y-range.
- When cell_valid=0: cell_col, cell_row, posx, posy, on_line, is_cursor and is_marked are all 0.
- posx = X0 + col*CELL_W + CELL_W/2, truncated to W bits. posy is computed the same way from Y0, row and CELL_H.
- on_line = cell_valid AND (x offset within the cell < LINE_W OR y offset within the cell < LINE_W).
- is_cursor and is_marked use the cursor and mask values registered at stage 2 of the same pixel.
- Cursor update, one per cycle:
  - Priority is up > down > left > right; only the highest-priority asserted move is applied.
  - up decrements row and wraps 0 -> ROWS-1; down increments row and wraps ROWS-1 -> 0.
  - left and right act on the column with the same wrap rule.
  - cursor_col and cursor_row are registered and update on the cycle after the pulse.
- Select and clear:
  - clr wins: when clr=1, mark_mask is zeroed on the next edge, and sel in the same cycle is ignored with no pulse.
  - Otherwise, when sel=1 the mask bit of the pre-move cursor cell (the value before any move in the same cycle) is tested.
  - Bit clear: set it, and sel_accept=1 for one cycle.
  - Bit set: mask unchanged, and sel_reject=1 for one cycle.
  - Both pulses appear on the cycle after sel. They are never both high.
- The pixel path and the cursor/mask path are independent; moves or sel never stall the pipeline.

Test Plan:
- Corner and centre decode: pix_valid=1, (96,2) -> 2 cycles later cell_valid=1, col=0, row=0, posx=208, posy=87, on_line=1. Then (432,257) -> col=1, row=1, posx=432, posy=257, on_line=0.
- Out-of-grid boundaries:
  - (767,511) -> col=2, row=2, posx=656, posy=427.
  - (768,300), (95,300), (300,512) -> cell_valid=0, all pixel outputs 0.
  - (300,100) with pix_valid=0 -> cell_valid=0.
- Cursor wrap and priority:
  - From reset, mv_left -> cursor (col 2, row 0); mv_up -> row 2.
  - mv_up+mv_right together -> row 1, col stays 2.
  - mv_down from row 2 -> row 0.
- Mark logic:
  - Cursor (0,0), sel -> sel_accept pulse, mark_mask=9'b000000001; sel again -> sel_reject pulse, mask unchanged.
  - clr+sel together -> mask 0, no pulses.
  - sel+mv_right together -> bit 0 marked, cursor col 1.
- Highlight: cursor (1,1), mark cell 4, drive pixel (432,257) -> is_cursor=1, is_marked=1. Drive (208,87) -> both 0.
- Reset mid-operation: drop rst_n asynchronously while pix_valid streams, with marks and cursor nonzero -> all outputs 0 without a clock edge. After release: cursor (0,0), mask 0, first valid output 2 cycles after the first post-reset pixel.
